// File: rtl/fetch_arb_if.sv
// Handshake bundle between the read/write controllers, the fetch arbiter
// and the line-fill engine.
interface fetch_arb_if #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned list_depth = 4
);
    localparam int unsigned tag_w = $clog2(list_depth);

    logic                  rd_fetch_req;
    logic [1:0]            rd_fetch_cmd;
    logic [tag_w-1:0]      rd_fetch_tag;
    logic [addr_width-1:0] rd_fetch_addr;
    logic                  rd_fetch_gnt;
    logic                  rd_fetch_done;

    logic                  wr_fetch_req;
    logic [1:0]            wr_fetch_cmd;
    logic [tag_w-1:0]      wr_fetch_tag;
    logic [addr_width-1:0] wr_fetch_addr;
    logic                  wr_fetch_gnt;
    logic                  wr_fetch_done;

    logic                  line_req;
    logic [1:0]            line_cmd;
    logic [tag_w-1:0]      line_tag;
    logic [addr_width-1:0] line_addr;
    logic                  line_ack;
    logic                  line_done;
    logic                  busy;

    // Arbiter view
    modport master (
        input  rd_fetch_req, rd_fetch_cmd, rd_fetch_tag, rd_fetch_addr,
        input  wr_fetch_req, wr_fetch_cmd, wr_fetch_tag, wr_fetch_addr,
        input  line_ack, line_done,
        output rd_fetch_gnt, rd_fetch_done, wr_fetch_gnt, wr_fetch_done,
        output line_req, line_cmd, line_tag, line_addr, busy
    );

    // Controllers + line-fill engine view
    modport slave (
        output rd_fetch_req, rd_fetch_cmd, rd_fetch_tag, rd_fetch_addr,
        output wr_fetch_req, wr_fetch_cmd, wr_fetch_tag, wr_fetch_addr,
        output line_ack, line_done,
        input  rd_fetch_gnt, rd_fetch_done, wr_fetch_gnt, wr_fetch_done,
        input  line_req, line_cmd, line_tag, line_addr, busy
    );
endinterface

// File: rtl/fetch_arb.sv
// Round-robin arbiter/sequencer sharing one line-fill engine between the
// read and write controllers; every output is a flop.
module fetch_arb #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned list_depth = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_arb_if.master  bus
);
    localparam int unsigned tag_w = $clog2(list_depth);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GRANT     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        DONE      = 3'd4
    } state_t;

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } side_t;

    typedef struct packed {
        logic [1:0]            cmd;
        logic [tag_w-1:0]      tag;
        logic [addr_width-1:0] addr;
    } fetch_t;

    state_t state_q, state_d;
    side_t  owner_q, owner_d;
    side_t  last_q, last_d;
    side_t  win;
    fetch_t line_q, line_d;

    logic rd_gnt_q, rd_gnt_d;
    logic wr_gnt_q, wr_gnt_d;
    logic rd_done_q, rd_done_d;
    logic wr_done_q, wr_done_d;
    logic line_req_q, line_req_d;
    logic busy_q, busy_d;

    // Next state, arbitration and next-output decode
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        line_d  = line_q;
        win     = SIDE_RD;

        case (state_q)
            IDLE: begin
                if (bus.rd_fetch_req || bus.wr_fetch_req) begin
                    // On a tie the side that did not win last time goes first
                    if (bus.rd_fetch_req && (!bus.wr_fetch_req || last_q == SIDE_WR))
                        win = SIDE_RD;
                    else
                        win = SIDE_WR;
                    owner_d = win;
                    last_d  = win;
                    if (win == SIDE_RD)
                        line_d = '{cmd: bus.rd_fetch_cmd, tag: bus.rd_fetch_tag,
                                   addr: bus.rd_fetch_addr};
                    else
                        line_d = '{cmd: bus.wr_fetch_cmd, tag: bus.wr_fetch_tag,
                                   addr: bus.wr_fetch_addr};
                    state_d = GRANT;
                end
            end
            GRANT: state_d = ISSUE;
            ISSUE: begin
                if (bus.line_ack)
                    state_d = bus.line_done ? DONE : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.line_done)
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rd_gnt_d   = (state_d == GRANT) && (owner_d == SIDE_RD);
        wr_gnt_d   = (state_d == GRANT) && (owner_d == SIDE_WR);
        rd_done_d  = (state_d == DONE)  && (owner_d == SIDE_RD);
        wr_done_d  = (state_d == DONE)  && (owner_d == SIDE_WR);
        line_req_d = (state_d == ISSUE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= SIDE_RD;
            last_q     <= SIDE_WR;
            line_q     <= '0;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            line_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            line_q     <= line_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            line_req_q <= line_req_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rd_fetch_gnt  = rd_gnt_q;
    assign bus.wr_fetch_gnt  = wr_gnt_q;
    assign bus.rd_fetch_done = rd_done_q;
    assign bus.wr_fetch_done = wr_done_q;
    assign bus.line_req      = line_req_q;
    assign bus.line_cmd      = line_q.cmd;
    assign bus.line_tag      = line_q.tag;
    assign bus.line_addr     = line_q.addr;
    assign bus.busy          = busy_q;
endmodule

// File: tb/tb_fetch_arb.sv
// Vector-table bench for fetch_arb: each record drives one cycle of inputs
// and queues the outputs expected after the following clock edge.
module tb_fetch_arb;
    localparam int unsigned AW = 32;
    localparam int unsigned LD = 4;

    // {cmd, tag, addr} payloads
    localparam logic [35:0] RP  = {2'b01, 2'd2, 32'h0000_1000};
    localparam logic [35:0] WP  = {2'b10, 2'd3, 32'h0000_2000};
    localparam logic [35:0] WP2 = {2'b10, 2'd3, 32'h0000_3000};
    localparam logic [35:0] ZP  = 36'h0;

    typedef struct packed {
        logic        rg;
        logic        wg;
        logic        rdn;
        logic        wdn;
        logic        lreq;
        logic        busy;
        logic [1:0]  cmd;
        logic [1:0]  tag;
        logic [31:0] addr;
    } out_t;

    typedef struct packed {
        logic rr;
        logic wr;
        logic ack;
        logic dn;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   vidx   = 0;
    vec_t tbl[$];
    out_t exp_q[$];

    fetch_arb_if #(.addr_width(AW), .list_depth(LD)) bus ();

    fetch_arb #(.addr_width(AW), .list_depth(LD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rr, input logic wr, input logic ack,
                                input logic dn, input logic [5:0] e,
                                input logic [35:0] p);
        vec_t m;
        m.rr  = rr;
        m.wr  = wr;
        m.ack = ack;
        m.dn  = dn;
        m.exp = {e, p};
        return m;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.rg   = bus.rd_fetch_gnt;
        o.wg   = bus.wr_fetch_gnt;
        o.rdn  = bus.rd_fetch_done;
        o.wdn  = bus.wr_fetch_done;
        o.lreq = bus.line_req;
        o.busy = bus.busy;
        o.cmd  = bus.line_cmd;
        o.tag  = bus.line_tag;
        o.addr = bus.line_addr;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt r/w=%b%b done r/w=%b%b req=%b busy=%b cmd=%h tag=%h addr=%h, expected gnt r/w=%b%b done r/w=%b%b req=%b busy=%b cmd=%h tag=%h addr=%h",
                     name, act.rg, act.wg, act.rdn, act.wdn, act.lreq, act.busy,
                     act.cmd, act.tag, act.addr, exp.rg, exp.wg, exp.rdn, exp.wdn,
                     exp.lreq, exp.busy, exp.cmd, exp.tag, exp.addr);
        end
    endtask

    task automatic run_vec(input vec_t v);
        out_t e;
        @(negedge clk);
        bus.rd_fetch_req = v.rr;
        bus.wr_fetch_req = v.wr;
        bus.line_ack     = v.ack;
        bus.line_done    = v.dn;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("vec%0d", vidx), sample(), e);
        vidx++;
    endtask

    task automatic apply(input int n);
        for (int i = 0; i < n; i++) begin
            if (tbl.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL table_underrun: got empty table, expected %0d more vectors", n - i);
                return;
            end
            run_vec(tbl.pop_front());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1);
    end

    initial begin
        logic [35:0] p;
        logic [5:0]  g, d;

        // Tie after reset with both sides held: rd, wr, rd, wr
        for (int k = 0; k < 4; k++) begin
            p = (k % 2 == 0) ? RP : WP;
            g = (k % 2 == 0) ? 6'b100001 : 6'b010001;
            d = (k % 2 == 0) ? 6'b001001 : 6'b000101;
            tbl.push_back(mk(1, 1, 0, 0, g,         p));
            tbl.push_back(mk(1, 1, 0, 0, 6'b000011, p));
            tbl.push_back(mk(1, 1, 1, 0, 6'b000001, p));
            tbl.push_back(mk(1, 1, 0, 1, d,         p));
            tbl.push_back(mk(1, 1, 0, 0, 6'b000000, p));
        end
        // Single read, ack two cycles into line_req, done five cycles later
        tbl.push_back(mk(1, 0, 0, 0, 6'b100001, RP));
        tbl.push_back(mk(1, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 1, 0, 6'b000001, RP));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 6'b000001, RP));
        tbl.push_back(mk(0, 0, 0, 1, 6'b001001, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000000, RP));
        // Done alone in ISSUE is ignored; ack+done goes straight to DONE
        tbl.push_back(mk(1, 0, 0, 0, 6'b100001, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 0, 1, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 1, 1, 6'b001001, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000000, RP));
        // Write with writeback; address changes after the grant
        tbl.push_back(mk(0, 1, 0, 0, 6'b010001, WP));
        tbl.push_back(mk(0, 1, 0, 0, 6'b000011, WP));
        tbl.push_back(mk(0, 0, 1, 0, 6'b000001, WP));
        tbl.push_back(mk(0, 0, 0, 1, 6'b000101, WP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000000, WP));
        // Spurious done in IDLE and GRANT
        tbl.push_back(mk(0, 0, 0, 1, 6'b000000, WP));
        tbl.push_back(mk(1, 0, 0, 1, 6'b100001, RP));
        tbl.push_back(mk(0, 0, 0, 1, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 1, 0, 6'b000001, RP));
        tbl.push_back(mk(0, 0, 0, 1, 6'b001001, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000000, RP));
        // Read up to WAIT_DONE, then reset
        tbl.push_back(mk(1, 0, 0, 0, 6'b100001, RP));
        tbl.push_back(mk(0, 0, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 0, 1, 0, 6'b000001, RP));
        // After reset: latched fields cleared, tie goes to rd, then wr
        tbl.push_back(mk(0, 0, 0, 0, 6'b000000, ZP));
        tbl.push_back(mk(1, 1, 0, 0, 6'b100001, RP));
        tbl.push_back(mk(1, 1, 0, 0, 6'b000011, RP));
        tbl.push_back(mk(0, 1, 1, 0, 6'b000001, RP));
        tbl.push_back(mk(0, 1, 0, 1, 6'b001001, RP));
        tbl.push_back(mk(0, 1, 0, 0, 6'b000000, RP));
        tbl.push_back(mk(0, 1, 0, 0, 6'b010001, WP2));

        rst_n             = 1'b0;
        bus.rd_fetch_req  = 1'b0;
        bus.wr_fetch_req  = 1'b0;
        bus.line_ack      = 1'b0;
        bus.line_done     = 1'b0;
        bus.rd_fetch_cmd  = RP[35:34];
        bus.rd_fetch_tag  = RP[33:32];
        bus.rd_fetch_addr = RP[31:0];
        bus.wr_fetch_cmd  = WP[35:34];
        bus.wr_fetch_tag  = WP[33:32];
        bus.wr_fetch_addr = WP[31:0];

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", sample(), '0);

        apply(20);
        apply(11);
        apply(5);
        apply(1);
        bus.wr_fetch_addr = WP2[31:0];
        apply(4);
        apply(7);
        apply(3);

        // Asynchronous reset while in WAIT_DONE, with line_done arriving
        @(negedge clk);
        rst_n            = 1'b0;
        bus.rd_fetch_req = 1'b0;
        bus.line_ack     = 1'b0;
        bus.line_done    = 1'b1;
        #1;
        check("reset_async", sample(), '0);
        @(posedge clk);
        #1;
        check("reset_mid_hold", sample(), '0);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.line_done = 1'b0;

        apply(7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_arb.md
# fetch_arb

Arbiter and sequencer for the shared line-fetch engine. It accepts line-fetch requests from the read controller and the write controller and grants one at a time using round-robin. It forwards the granted command, tag and address to the line-fill engine and holds them stable for the whole transfer. It routes the completion pulse back to the requester that owns the transfer. The block sits between the two controllers' `fetch_*` ports and the single line-fill engine.

## Interface
- `addr_width`, 32, fetch address width.
- `list_depth`, 4, number of cache lines; tag width is `$clog2(list_depth)`.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rd_fetch_req`  in  1  read-side request; held until granted.
- `rd_fetch_cmd`  in  2  read-side command (2'b01 fetch, 2'b10 writeback+fetch).
- `rd_fetch_tag`  in  `$clog2(list_depth)`  read-side line tag.
- `rd_fetch_addr`  in  `addr_width`  read-side line address.
- `rd_fetch_gnt`  out  1  one-cycle grant to the read side.
- `rd_fetch_done`  out  1  one-cycle completion to the read side.
- `wr_fetch_req`, `wr_fetch_cmd`, `wr_fetch_tag`, `wr_fetch_addr`  in  same as read side  write-side request.
- `wr_fetch_gnt`, `wr_fetch_done`  out  1  write-side grant and completion.
- `line_req`  out  1  request to the line-fill engine.
- `line_cmd`  out  2  latched command.
- `line_tag`  out  `$clog2(list_depth)`  latched tag.
- `line_addr`  out  `addr_width`  latched address.
- `line_ack`  in  1  engine accepts `line_req` (handshake is `line_req && line_ack`).
- `line_done`  in  1  one-cycle pulse when the engine finishes the transfer.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States and transitions:
  - IDLE: if any request is present, go to GRANT.
  - GRANT: go to ISSUE.
  - ISSUE: on `line_ack`, go to WAIT_DONE. If `line_ack` and `line_done` arrive in the same cycle, go to DONE.
  - WAIT_DONE: on `line_done`, go to DONE.
  - DONE: go to IDLE.
- Arbitration is evaluated in IDLE only.
  - If one side requests, that side wins.
  - If both sides request, the side that is not `last_owner` wins.
- On the winning IDLE cycle:
  - `owner` latches the winning side.
  - `last_owner` updates to the winning side.
  - The winner's cmd, tag and addr are latched into `line_cmd`, `line_tag` and `line_addr`.
- GRANT asserts the owner's `*_fetch_gnt` for exactly one cycle.
- ISSUE holds `line_req` high until `line_ack`.
- DONE asserts the owner's `*_fetch_done` for exactly one cycle. The non-owner side never sees `gnt` or `done`.
- `line_cmd`, `line_tag` and `line_addr` change only on a winning IDLE cycle. They are stable from GRANT through DONE.
- `line_done` is ignored in IDLE and GRANT. It is also ignored in ISSUE unless it coincides with `line_ack`.
- A request dropped after the winning cycle does not cancel the transfer; the sequence completes.
- Requests arriving in any state other than IDLE are held by the requester and arbitrated on return to IDLE.
- Reset values:
  - State is IDLE; `owner` = rd; `last_owner` = wr, so the read side wins the first tie.
  - All outputs are 0: `rd/wr_fetch_gnt`, `rd/wr_fetch_done`, `line_req`, `line_cmd`, `line_tag`, `line_addr`, `busy`.
- Reset mid-transfer returns immediately to IDLE with all outputs 0. No done pulse is generated.

## Timing
- All outputs are registered or decoded from state and latched registers only. There are no combinational paths from inputs to outputs.
- Request seen in IDLE at cycle N:
  - `*_fetch_gnt` is high at N+1.
  - `line_req` is high from N+2.
- `line_ack` at cycle A (A ≥ N+2) gives WAIT_DONE at A+1.
- `line_done` at cycle D gives `*_fetch_done` at D+1 and IDLE at D+2.
- With a held request, the earliest next grant is D+3.
- Back-to-back requests alternate rd/wr under continuous contention.

## Test plan
- Single read: `rd_fetch_req` with cmd=2'b01, tag=2, addr=0x1000; `line_ack` 2 cycles after `line_req`; `line_done` 5 cycles later.
  - Expect `rd_fetch_gnt` pulse at N+1 and `line_req` from N+2.
  - Expect `line_tag`=2 and `line_addr`=0x1000 stable until DONE.
  - Expect a single `rd_fetch_done` pulse and no `wr_*` activity.
- Tie after reset: `rd_fetch_req` and `wr_fetch_req` both high at cycle 0.
  - Expect rd granted first; wr granted at the next IDLE.
  - With both held continuously, grant order is rd, wr, rd, wr.
- Write with writeback: wr cmd=2'b10, tag=3.
  - Expect `line_cmd`=2'b10 and `line_tag`=3.
  - Changing `wr_fetch_addr` after the grant leaves `line_addr` unchanged.
- Simultaneous ack and done: `line_ack` and `line_done` high in the same ISSUE cycle.
  - Expect a direct ISSUE→DONE transition and exactly one owner done pulse.
- Spurious done: `line_done` pulsed in IDLE and in GRANT.
  - Expect no `*_fetch_done` output and no state change beyond the normal sequence.
- Reset mid-transfer: assert `rst_n`=0 in WAIT_DONE.
  - Expect all outputs 0, IDLE, and no done pulse.
  - After release, a tie grants rd first.
